alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_if.sv | 60 ++++++
 rtl/alu_arbiter.sv | 150 +++++++++++++++
 tb/tb_alu_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: requester and shared-ALU bus of the two-port ALU arbiter.
// slave = arbiter view; master = requesters plus the ALU datapath.
interface alu_arbiter_if #(
  parameter int DATA_WIDTH = 32
);

  // requester 0 / 1 request side
  logic                  Req0;
  logic                  Req1;
  logic [3:0]            Ctl0;
  logic [3:0]            Ctl1;
  logic [DATA_WIDTH-1:0] A0;
  logic [DATA_WIDTH-1:0] B0;
  logic [DATA_WIDTH-1:0] A1;
  logic [DATA_WIDTH-1:0] B1;

  // handshake and result side
  logic                  Gnt0;
  logic                  Gnt1;
  logic                  Done0;
  logic                  Done1;
  logic [DATA_WIDTH-1:0] Result;
  logic                  Zero;
  logic                  Err;
  logic                  Busy;

  // shared ALU side
  logic [3:0]            ALUControl;
  logic [DATA_WIDTH-1:0] DataIn0;
  logic [DATA_WIDTH-1:0] DataIn1;
  logic [DATA_WIDTH-1:0] DataOut;
  logic                  ZeroOut;

  modport slave (
    input  Req0, Req1,
    input  Ctl0, Ctl1,
    input  A0, B0, A1, B1,
    input  DataOut, ZeroOut,
    output Gnt0, Gnt1,
    output Done0, Done1,
    output Result, Zero, Err,
    output Busy,
    output ALUControl,
    output DataIn0, DataIn1
  );

  modport master (
    output Req0, Req1,
    output Ctl0, Ctl1,
    output A0, B0, A1, B1,
    output DataOut, ZeroOut,
    input  Gnt0, Gnt1,
    input  Done0, Done1,
    input  Result, Zero, Err,
    input  Busy,
    input  ALUControl,
    input  DataIn0, DataIn1
  );

endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between two requesters, 3-cycle op (IDLE/ISSUE/CAPTURE).
// Ports: Clock, Reset (async, high), bus (alu_arbiter_if.slave: Req/Ctl/A/B in, Gnt/Done/Result out, ALU drives).
module alu_arbiter #(
  parameter int DATA_WIDTH = 32
) (
  input logic          Clock,
  input logic          Reset,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } state_e;

  state_e state_q, state_d;

  // last_q doubles as the current owner: it only moves on a grant
  logic last_q, last_d;

  logic [3:0]            ctl_q, ctl_d;
  logic [DATA_WIDTH-1:0] din0_q, din0_d;
  logic [DATA_WIDTH-1:0] din1_q, din1_d;

  logic [DATA_WIDTH-1:0] res_q, res_d;
  logic                  zero_q, zero_d;
  logic                  err_q, err_d;

  logic done0_q, done0_d;
  logic done1_q, done1_d;

  logic gnt0;
  logic gnt1;
  logic pick1;
  logic any_req;
  logic ctl_ok;

  // requester 1 wins alone, or on a tie when 0 owned last
  assign any_req = bus.Req0 | bus.Req1;
  assign pick1   = bus.Req1 & (~bus.Req0 | ~last_q);

  always_comb begin
    ctl_ok = 1'b0;
    unique case (1'b1)
      (ctl_q == 4'b0000): ctl_ok = 1'b1;
      (ctl_q == 4'b0001): ctl_ok = 1'b1;
      (ctl_q == 4'b0010): ctl_ok = 1'b1;
      (ctl_q == 4'b0110): ctl_ok = 1'b1;
      (ctl_q == 4'b0111): ctl_ok = 1'b1;
      (ctl_q == 4'b1100): ctl_ok = 1'b1;
      default:            ctl_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    ctl_d   = ctl_q;
    din0_d  = din0_q;
    din1_d  = din1_q;
    res_d   = res_q;
    zero_d  = zero_q;
    err_d   = err_q;
    done0_d = 1'b0;
    done1_d = 1'b0;
    gnt0    = 1'b0;
    gnt1    = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Reset gating keeps Gnt low while held in reset
        if (any_req && !Reset) begin
          gnt0    = ~pick1;
          gnt1    = pick1;
          last_d  = pick1;
          ctl_d   = pick1 ? bus.Ctl1 : bus.Ctl0;
          din0_d  = pick1 ? bus.A1 : bus.A0;
          din1_d  = pick1 ? bus.B1 : bus.B0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        res_d   = bus.DataOut;
        zero_d  = bus.ZeroOut;
        err_d   = ~ctl_ok;
        done0_d = ~last_q;
        done1_d = last_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      ctl_q   <= '0;
      din0_q  <= '0;
      din1_q  <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      ctl_q   <= ctl_d;
      din0_q  <= din0_d;
      din1_q  <= din1_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
    end
  end

  assign bus.Gnt0       = gnt0;
  assign bus.Gnt1       = gnt1;
  assign bus.Done0      = done0_q;
  assign bus.Done1      = done1_q;
  assign bus.Result     = res_q;
  assign bus.Zero       = zero_q;
  assign bus.Err        = err_q;
  assign bus.Busy       = (state_q != IDLE);
  assign bus.ALUControl = ctl_q;
  assign bus.DataIn0    = din0_q;
  assign bus.DataIn1    = din1_q;

  a_gnt_mx: assert property (
    @(posedge Clock) disable iff (Reset)
    !(bus.Gnt0 && bus.Gnt1));

  a_done_mx: assert property (
    @(posedge Clock) disable iff (Reset)
    !(bus.Done0 && bus.Done1));

  a_no_gnt_busy: assert property (
    @(posedge Clock) disable iff (Reset)
    bus.Busy |-> !(bus.Gnt0 || bus.Gnt1));

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed + random requests against a cycle-count model.
// The bench also plays the shared ALU.
module tb_alu_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_arbiter_if #(.DATA_WIDTH(32)) bus ();

  alu_arbiter #(.DATA_WIDTH(32)) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus)
  );

  function automatic logic [31:0] alu_f(
    input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1100: return ~(a | b);
      default: return a ^ b;
    endcase
  endfunction

  function automatic bit ok_code(input logic [3:0] c);
    return (c == 4'd0) || (c == 4'd1) || (c == 4'd2) ||
           (c == 4'd6) || (c == 4'd7) || (c == 4'd12);
  endfunction

  assign bus.DataOut = alu_f(bus.ALUControl, bus.DataIn0, bus.DataIn1);
  assign bus.ZeroOut = (bus.DataOut == 32'd0);

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // next-cycle requester drive
  logic        n_req0 = 0, n_req1 = 0;
  logic [3:0]  n_ctl0 = 0, n_ctl1 = 0;
  logic [31:0] n_a0 = 0, n_b0 = 0, n_a1 = 0, n_b1 = 0;
  bit          keep_req = 0;
  bit          rnd = 0;

  // reference model state
  int          free_at = 0;
  bit          m_last = 1;
  bit          pend_v = 0;
  int          pend_cyc = 0;
  bit          pend_own = 0;
  logic [31:0] pend_res = 0;
  bit          pend_err = 0;
  logic [31:0] h_res = 0;
  bit          h_zero = 0;
  bit          h_err = 0;
  logic [3:0]  cur_ctl = 0;
  logic [31:0] cur_a = 0, cur_b = 0;

  logic [3:0] codes [8] = '{4'd0, 4'd1, 4'd2, 4'd6,
                            4'd7, 4'd12, 4'd15, 4'd9};

  task automatic rnd_op(output logic [3:0] c,
                        output logic [31:0] a,
                        output logic [31:0] b);
    c = codes[$urandom_range(0, 7)];
    a = $urandom;
    b = ($urandom_range(0, 3) == 0) ? a : $urandom;
  endtask

  task automatic model_reset();
    free_at  = cyc;
    m_last   = 1;
    pend_v   = 0;
    h_res    = 0;
    h_zero   = 0;
    h_err    = 0;
    cur_ctl  = 0;
    cur_a    = 0;
    cur_b    = 0;
  endtask

  task automatic drive();
    bus.Req0 = n_req0; bus.Req1 = n_req1;
    bus.Ctl0 = n_ctl0; bus.Ctl1 = n_ctl1;
    bus.A0 = n_a0; bus.B0 = n_b0;
    bus.A1 = n_a1; bus.B1 = n_b1;
  endtask

  task automatic step();
    bit idle, e0, e1, d0, d1;
    idle = (cyc >= free_at);
    e0 = 0;
    e1 = 0;
    if (idle) begin
      if (bus.Req0 && bus.Req1) begin
        e0 = m_last;
        e1 = !m_last;
      end else begin
        e0 = bus.Req0;
        e1 = bus.Req1;
      end
    end
    d0 = 0;
    d1 = 0;
    if (pend_v && pend_cyc == cyc) begin
      d0 = !pend_own;
      d1 = pend_own;
      h_res  = pend_res;
      h_zero = (pend_res == 32'd0);
      h_err  = pend_err;
      pend_v = 0;
    end
    chk("gnt0", 32'(bus.Gnt0), 32'(e0));
    chk("gnt1", 32'(bus.Gnt1), 32'(e1));
    chk("gnt_mx", 32'(bus.Gnt0 & bus.Gnt1), 32'd0);
    chk("done0", 32'(bus.Done0), 32'(d0));
    chk("done1", 32'(bus.Done1), 32'(d1));
    chk("done_mx", 32'(bus.Done0 & bus.Done1), 32'd0);
    chk("busy", 32'(bus.Busy), 32'(!idle));
    chk("result", bus.Result, h_res);
    chk("zero", 32'(bus.Zero), 32'(h_zero));
    chk("err", 32'(bus.Err), 32'(h_err));
    chk("aluctl", 32'(bus.ALUControl), 32'(cur_ctl));
    chk("din0", bus.DataIn0, cur_a);
    chk("din1", bus.DataIn1, cur_b);
    if (e0 || e1) begin
      m_last   = e1;
      free_at  = cyc + 3;
      pend_v   = 1;
      pend_cyc = cyc + 3;
      pend_own = e1;
      cur_ctl  = e1 ? bus.Ctl1 : bus.Ctl0;
      cur_a    = e1 ? bus.A1 : bus.A0;
      cur_b    = e1 ? bus.B1 : bus.B0;
      pend_res = alu_f(cur_ctl, cur_a, cur_b);
      pend_err = !ok_code(cur_ctl);
      if (!keep_req) begin
        if (e0) n_req0 = 0;
        if (e1) n_req1 = 0;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    rst = 1'b0;
    if (rnd) begin
      if (!n_req0 && $urandom_range(0, 2) == 0) begin
        n_req0 = 1;
        rnd_op(n_ctl0, n_a0, n_b0);
      end
      if (!n_req1 && $urandom_range(0, 2) == 0) begin
        n_req1 = 1;
        rnd_op(n_ctl1, n_a1, n_b1);
      end
    end
    drive();
    #1;
    step();
  endtask

  task automatic reset_tick();
    @(negedge clk);
    rst = 1'b1;
    drive();
    #1;
    model_reset();
    chk("rst_gnt0", 32'(bus.Gnt0), 32'd0);
    chk("rst_gnt1", 32'(bus.Gnt1), 32'd0);
    chk("rst_done0", 32'(bus.Done0), 32'd0);
    chk("rst_done1", 32'(bus.Done1), 32'd0);
    chk("rst_busy", 32'(bus.Busy), 32'd0);
    chk("rst_result", bus.Result, 32'd0);
    chk("rst_zero", 32'(bus.Zero), 32'd0);
    chk("rst_err", 32'(bus.Err), 32'd0);
    chk("rst_aluctl", 32'(bus.ALUControl), 32'd0);
    chk("rst_din0", bus.DataIn0, 32'd0);
    chk("rst_din1", bus.DataIn1, 32'd0);
  endtask

  // called in the grant cycle; returns cycles until owner's Done, or -1
  task automatic wait_done(input bit who, output int lat);
    int s;
    s = cyc;
    lat = -1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (who ? bus.Done1 : bus.Done0) begin
        lat = cyc - s;
        break;
      end
    end
  endtask

  task automatic drain(input int n);
    n_req0 = 0;
    n_req1 = 0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [31:0] exp_r;
    drive();
    reset_tick();
    reset_tick();

    // single add from reset
    n_req0 = 1; n_ctl0 = 4'b0010; n_a0 = 1; n_b0 = 2;
    tick();
    chk("r034_gnt0", 32'(bus.Gnt0), 32'd1);
    wait_done(0, lat);
    chk("r034_lat", lat, 32'd3);
    chk("r034_res", bus.Result, 32'd3);
    chk("r034_zero", 32'(bus.Zero), 32'd0);
    chk("r034_err", 32'(bus.Err), 32'd0);
    drain(2);

    // held tie alternates 0,1,0,1
    reset_tick();
    keep_req = 1;
    n_req0 = 1; n_ctl0 = 4'b0010; n_a0 = 32'h8000_0001; n_b0 = 1;
    n_req1 = 1; n_ctl1 = 4'b0111; n_a1 = 32'hFFFF_FFFF; n_b1 = 3;
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("r035_gnt1", 32'(bus.Gnt1), 32'(k % 2));
      chk("r035_gnt0", 32'(bus.Gnt0), 32'((k + 1) % 2));
      wait_done((k % 2) == 1, lat);
      exp_r = (k % 2 == 1) ? 32'd1 : 32'h8000_0002;
      chk("r035_lat", lat, 32'd3);
      chk("r035_res", bus.Result, exp_r);
    end
    keep_req = 0;
    drain(4);

    // subtract: zero and non-zero
    n_req1 = 1; n_ctl1 = 4'b0110; n_a1 = 4; n_b1 = 4;
    tick();
    wait_done(1, lat);
    chk("r036_res_a", bus.Result, 32'd0);
    chk("r036_zero_a", 32'(bus.Zero), 32'd1);
    n_req1 = 1; n_a1 = 4; n_b1 = 0;
    tick();
    wait_done(1, lat);
    chk("r036_res_b", bus.Result, 32'd4);
    chk("r036_zero_b", 32'(bus.Zero), 32'd0);

    // unsupported code then valid add
    n_req0 = 1; n_ctl0 = 4'b1111; n_a0 = 7; n_b0 = 9;
    tick();
    wait_done(0, lat);
    chk("r037_err", 32'(bus.Err), 32'd1);
    n_req0 = 1; n_ctl0 = 4'b0010; n_a0 = 5; n_b0 = 6;
    tick();
    wait_done(0, lat);
    chk("r037_err_clr", 32'(bus.Err), 32'd0);
    chk("r037_res", bus.Result, 32'd11);

    // request 1 raised while busy with 0
    n_req0 = 1; n_ctl0 = 4'b0000; n_a0 = $urandom; n_b0 = $urandom;
    tick();
    chk("r038_g0", 32'(bus.Gnt0), 32'd1);
    n_req1 = 1; n_ctl1 = 4'b0001; n_a1 = $urandom; n_b1 = $urandom;
    tick();
    chk("r038_issue_g1", 32'(bus.Gnt1), 32'd0);
    tick();
    chk("r038_capt_g1", 32'(bus.Gnt1), 32'd0);
    tick();
    chk("r038_idle_g1", 32'(bus.Gnt1), 32'd1);
    chk("r038_done0", 32'(bus.Done0), 32'd1);
    wait_done(1, lat);
    chk("r038_lat", lat, 32'd3);

    // reset during CAPTURE; next tie goes to 0
    n_req0 = 1; n_ctl0 = 4'b0010; n_a0 = 1; n_b0 = 1;
    tick();
    tick();
    reset_tick();
    keep_req = 1;
    n_req0 = 1; n_req1 = 1;
    n_ctl1 = 4'b0010; n_a1 = 2; n_b1 = 2;
    tick();
    chk("r039_tie_g0", 32'(bus.Gnt0), 32'd1);
    chk("r039_tie_g1", 32'(bus.Gnt1), 32'd0);
    keep_req = 0;
    wait_done(0, lat);
    chk("r039_res", bus.Result, 32'd2);
    drain(4);

    // random traffic with occasional resets
    rnd = 1;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 299) == 0) reset_tick();
      else tick();
    end
    rnd = 0;
    drain(5);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
